// File: rtl/pe_window_feeder.sv
// pe_window_feeder
//   Upstream feeder for a 3x3 convolution PE. Takes a raster-order pixel
//   stream, keeps two previous image lines plus a sliding 3x3 window, and
//   for every complete window emits nine (pixel, weight) pairs, tap 0..8 in
//   row-major order on consecutive cycles.
//
// Optional feature: define PE_FEED_WIN_IDX_EN to add the win_idx output
//   (0-based index of the window being emitted, cleared at frame end).
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   w_load      weight write strobe (ignored while emitting)
//   w_addr      weight index 0..8, 9..15 ignored
//   w_data      weight value
//   pix_valid   input pixel valid
//   pix_ready   feeder can accept a pixel
//   pix_data    input pixel, raster order
//   pe_in       pixel tap to the PE (0 when pe_vld=0)
//   pe_filter   matching weight (0 when pe_vld=0)
//   pe_vld      high during the nine tap cycles
//   pe_last     high on tap 8
//   frame_done  one-cycle pulse after the last window of a frame
//   win_idx     [PE_FEED_WIN_IDX_EN only] current window index
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_ACCEPT | pix_ready=1, take pixels; a pixel at row>=2,col>=2 triggers
// S_EMIT   | pix_ready=0, taps 0..8 on the PE outputs
// S_DONE   | one cycle frame_done pulse, row/col cleared

module pe_window_feeder #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_load,
    input  logic [3:0]        w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] pe_in,
    output logic [DATA_W-1:0] pe_filter,
    output logic              pe_vld,
    output logic              pe_last,
    output logic              frame_done
`ifdef PE_FEED_WIN_IDX_EN
    ,
    output logic [15:0]       win_idx
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_EMIT   = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [3:0]        tap_q;
    logic              last_win_q;

    // lb_a holds row r-2, lb_b holds row r-1, both indexed by column.
    logic [DATA_W-1:0] lb_a [IMG_W];
    logic [DATA_W-1:0] lb_b [IMG_W];

    // win_q[3*i+j]: window row i (0 = top), column j (0 = left).
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic [DATA_W-1:0] wt_q  [9];
    logic [DATA_W-1:0] wt_d  [9];

    logic       accept;
    logic       trigger;
    logic       at_end;
    logic       load_tap;
    logic [3:0] tap_sel;

    assign accept   = pix_valid && (state_q == S_ACCEPT);
    assign trigger  = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign at_end   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign load_tap = trigger || ((state_q == S_EMIT) && (tap_q != 4'd8));
    assign tap_sel  = trigger ? 4'd0 : (tap_q + 4'd1);

    // Sliding window: each accepted pixel shifts in a new right-hand column
    // built from the two line buffers and the incoming pixel. Columns from a
    // previous row are stale after a wrap but are shifted out before any
    // trigger (col>=2).
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2] = lb_a[col_q];
            win_d[5] = lb_b[col_q];
            win_d[8] = pix_data;
        end
    end

    // Writes are blocked in EMIT so a window sees one consistent weight set.
    // The post-write value feeds tap 0 directly so a same-edge write lands
    // in the triggered window.
    always_comb begin
        wt_d = wt_q;
        if (w_load && (state_q != S_EMIT) && (w_addr <= 4'd8)) begin
            wt_d[w_addr] = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                pix_ready = 1'b1;
                if (trigger) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tap_q == 4'd8) begin
                    state_d = last_win_q ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_ACCEPT;
            end
            default: begin
                state_d = S_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            tap_q      <= '0;
            last_win_q <= 1'b0;
            pe_in      <= '0;
            pe_filter  <= '0;
            pe_vld     <= 1'b0;
            pe_last    <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                lb_a[i] <= '0;
                lb_b[i] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
                wt_q[k]  <= '0;
            end
        end else begin
            win_q <= win_d;
            wt_q  <= wt_d;

            if (accept) begin
                lb_a[col_q] <= lb_b[col_q];
                lb_b[col_q] <= pix_data;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end else if (state_q == S_DONE) begin
                col_q <= '0;
                row_q <= '0;
            end

            if (trigger) begin
                last_win_q <= at_end;
            end

            if (load_tap) begin
                tap_q     <= tap_sel;
                pe_vld    <= 1'b1;
                pe_last   <= (tap_sel == 4'd8);
                pe_in     <= win_d[tap_sel];
                pe_filter <= wt_d[tap_sel];
            end else begin
                tap_q     <= '0;
                pe_vld    <= 1'b0;
                pe_last   <= 1'b0;
                pe_in     <= '0;
                pe_filter <= '0;
            end
        end
    end

`ifdef PE_FEED_WIN_IDX_EN
    // Advances as tap 8 retires; the final window of a frame returns it to 0
    // so it already reads 0 while frame_done is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_idx <= '0;
        end else if ((state_q == S_EMIT) && (tap_q == 4'd8)) begin
            win_idx <= last_win_q ? 16'd0 : (win_idx + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_pe_window_feeder.sv
// Testbench for pe_window_feeder: cycle-by-cycle comparison against a
// queue-based reference model driven by a whole-frame image array.

module tb_pe_window_feeder;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_load = 1'b0;
    logic [3:0]    w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic [DW-1:0] pe_in;
    logic [DW-1:0] pe_filter;
    logic          pe_vld;
    logic          pe_last;
    logic          frame_done;
`ifdef PE_FEED_WIN_IDX_EN
    logic [15:0]   win_idx;
`endif

    pe_window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_load     (w_load),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pe_in      (pe_in),
        .pe_filter  (pe_filter),
        .pe_vld     (pe_vld),
        .pe_last    (pe_last),
        .frame_done (frame_done)
`ifdef PE_FEED_WIN_IDX_EN
        ,
        .win_idx    (win_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rdy;
        logic          vld;
        logic          last;
        logic          done;
        logic [DW-1:0] din;
        logic [DW-1:0] filt;
        logic [15:0]   idx;
    } rec_t;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] img [H][W];
    logic [DW-1:0] wt [9];
    int            pos = 0;
    int            win_count = 0;
    rec_t          q [$];
    rec_t          cur;
    int            lasts_seen = 0;
    int            dones_seen = 0;
    logic [DW-1:0] capbuf [9];
    logic [DW-1:0] firstwin [9];
    bit            first_got = 0;
    int            tb_tap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.rdy = 1'b1;
        r.idx = 16'(win_count);
        return r;
    endfunction

    task automatic compare_cur();
        check("pix_ready", {31'd0, pix_ready}, {31'd0, cur.rdy});
        check("pe_vld", {31'd0, pe_vld}, {31'd0, cur.vld});
        check("pe_last", {31'd0, pe_last}, {31'd0, cur.last});
        check("frame_done", {31'd0, frame_done}, {31'd0, cur.done});
        check("pe_in", {24'd0, pe_in}, {24'd0, cur.din});
        check("pe_filter", {24'd0, pe_filter}, {24'd0, cur.filt});
`ifdef PE_FEED_WIN_IDX_EN
        if (cur.vld || cur.rdy) check("win_idx", {16'd0, win_idx}, {16'd0, cur.idx});
`endif
        if (pe_last === 1'b1) lasts_seen++;
        if (frame_done === 1'b1) dones_seen++;
        if (pe_vld === 1'b1) begin
            if (tb_tap < 9) capbuf[tb_tap] = pe_in;
            if (pe_last === 1'b1) begin
                if (!first_got) begin
                    firstwin  = capbuf;
                    first_got = 1;
                end
                tb_tap = 0;
            end else begin
                tb_tap++;
            end
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare outputs.
    task automatic tick(input bit valid, input bit wl, input logic [3:0] wa, input logic [DW-1:0] wd);
        rec_t rec;
        int   r, c;
        pix_valid = valid;
        pix_data  = img[pos / W][pos % W];
        w_load    = wl;
        w_addr    = wa;
        w_data    = wd;
        @(posedge clk);
        #1;
        if (wl && !cur.vld && wa <= 4'd8) wt[wa] = wd;
        if (valid && cur.rdy) begin
            r = pos / W;
            c = pos % W;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    rec      = '0;
                    rec.vld  = 1'b1;
                    rec.last = (k == 8);
                    rec.din  = img[r - 2 + k / 3][c - 2 + k % 3];
                    rec.filt = wt[k];
                    rec.idx  = 16'(win_count);
                    q.push_back(rec);
                end
                win_count++;
                if (pos == W * H - 1) begin
                    rec      = '0;
                    rec.done = 1'b1;
                    q.push_back(rec);
                    win_count = 0;
                end
            end
            pos = (pos + 1) % (W * H);
        end
        cur = (q.size() > 0) ? q.pop_front() : idle_rec();
        compare_cur();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        pix_valid = 1'b0;
        w_load    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        pos       = 0;
        win_count = 0;
        tb_tap    = 0;
        for (int k = 0; k < 9; k++) wt[k] = '0;
        cur = idle_rec();
        compare_cur();
    endtask

    // kind 0: all = val, 1: ramp 0..8, 2: random
    task automatic load_w(input int kind, input int val);
        logic [DW-1:0] d;
        for (int k = 0; k < 9; k++) begin
            d = (kind == 0) ? DW'(val) : (kind == 1) ? DW'(k) : DW'($urandom_range(255));
            tick(1'b0, 1'b1, 4'(k), d);
        end
    endtask

    // kind 0: constant val, 1: ramp 8r+c, 2: random
    task automatic fill_img(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (kind == 0) ? DW'(val) : (kind == 1) ? DW'(W * r + c) : DW'($urandom_range(255));
    endtask

    // wl_mode 0: none, 1: random writes, 2: (0,99) on every EMIT cycle,
    // 3: (0,99) on every ACCEPT cycle
    task automatic run_frame(input int vprob, input int wl_mode);
        int            start, n;
        bit            v, wl;
        logic [3:0]    wa;
        logic [DW-1:0] wd;
        start = dones_seen;
        n = 0;
        while (dones_seen == start && n < 3000) begin
            v  = ($urandom_range(99) < vprob);
            wl = 1'b0;
            wa = 4'd0;
            wd = 8'd99;
            case (wl_mode)
                1: begin
                    wl = ($urandom_range(3) == 0);
                    wa = 4'($urandom_range(15));
                    wd = DW'($urandom_range(255));
                end
                2: wl = cur.vld;
                3: wl = cur.rdy;
                default: wl = 1'b0;
            endcase
            tick(v, wl, wa, wd);
            n++;
        end
        check("frame_completes", dones_seen - start, 1);
        repeat (2) tick(1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic check_win(input string tag, input logic [DW-1:0] got [9], input logic [DW-1:0] exp [9]);
        for (int k = 0; k < 9; k++) check(tag, {24'd0, got[k]}, {24'd0, exp[k]});
    endtask

    logic [DW-1:0] exp_first [9];
    logic [DW-1:0] exp_last  [9];
    int            l0, d0, n;

    initial begin
        exp_first = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
        exp_last  = '{8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63};
        fill_img(0, 0);
        do_reset();

        // all-ones image and weights, continuous valid
        load_w(0, 1);
        fill_img(0, 1);
        l0 = lasts_seen;
        d0 = dones_seen;
        run_frame(100, 0);
        check("windows_per_frame", lasts_seen - l0, 36);
        check("frame_done_pulses", dones_seen - d0, 1);

        // ramp image, ramp weights
        fill_img(1, 0);
        load_w(1, 0);
        first_got = 0;
        run_frame(100, 0);
        check_win("ramp_first_window", firstwin, exp_first);
        check_win("ramp_last_window", capbuf, exp_last);

        // writes during EMIT are ignored, writes during ACCEPT land
        run_frame(100, 2);
        run_frame(100, 3);
        check("w0_after_accept_write", {24'd0, wt[0]}, 32'd99);

        // random images, weights, valid gaps and weight writes
        repeat (2) begin
            fill_img(2, 0);
            load_w(2, 0);
            run_frame(60, 1);
        end

        // reset in the middle of a window (tap 4)
        fill_img(1, 0);
        load_w(1, 0);
        n = 0;
        while (!(cur.vld && q.size() == 4) && n < 200) begin
            tick(1'b1, 1'b0, 4'd0, '0);
            n++;
        end
        do_reset();
        load_w(1, 0);
        first_got = 0;
        run_frame(100, 0);
        check_win("post_reset_first_window", firstwin, exp_first);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
